matmul_ctrl: RTL and testbench
==============================

MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 3, matrix dimension; DW, default 8, operand width; RW, default 16, result width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, the single clock.
- rst, input, 1, reset; asynchronous, active-high.
- ld_en, input, 1, write one operand.
- ld_sel, input, 1, 0 = matrix A, 1 = matrix B.
- ld_addr, input, 4, row-major index 0..8.
- ld_data, input, 8, signed operand.
- start, input, 1, begin multiply (pulse).
- a_i_0/a_i_1/a_i_2, output, 8 each, signed A row to the MAC.
- b_j_0/b_j_1/b_j_2, output, 8 each, signed B column to the MAC.
- W_en, output, 1, MAC write enable.
- SOP, input, 16, signed MAC result.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts the result.
- res_data, output, 16, signed C element.
- res_idx, output, 4, C row-major index.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse after the last result is accepted.

Function
REQ-003 While busy=0, ld_en=1 SHALL write ld_data into A[ld_addr] or B[ld_addr], selected by ld_sel; ld_addr>8 SHALL be ignored.
REQ-004 While busy=1, ld_en SHALL be ignored.
REQ-005 The FSM states SHALL be IDLE, FEED, CAPT and DRAIN.
REQ-006 IDLE->FEED SHALL occur on start=1; busy SHALL rise in the next cycle and element index k SHALL be set to 0.
REQ-007 In FEED, for k=(i,j), the block SHALL drive a_i_n=A[i][n] and b_j_n=B[n][j] for n=0..2, with W_en=1 for exactly that one cycle.
REQ-008 FEED SHALL always go to CAPT.
REQ-009 In CAPT, W_en SHALL be 0, operands SHALL be held, and SOP SHALL be sampled into C[k].
REQ-010 From CAPT, k<8 SHALL increment k and return to FEED; k=8 SHALL go to DRAIN with the output index at 0.
REQ-011 The compute phase SHALL take exactly 18 cycles (9 x FEED/CAPT) from the first FEED.
REQ-012 In DRAIN, res_valid=1, res_data=C[idx] and res_idx=idx.
REQ-013 A transfer SHALL occur on res_valid & res_ready, and SHALL advance idx.
REQ-014 Without a transfer, res_data and res_idx SHALL remain stable.
REQ-015 The transfer at idx=8 SHALL go to IDLE, pulse done for one cycle and clear busy in that same cycle.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 start and ld_en asserted together in IDLE SHALL both take effect; the load completes before the first FEED reads.
REQ-018 SOP SHALL be stored verbatim (16-bit two's complement) with no saturation or re-widening.
REQ-019 The index SHALL never wrap past 8.
REQ-020 Outside FEED and CAPT, the operand outputs SHALL be 0.
REQ-021 W_en SHALL be 1 only in FEED.

Reset
REQ-022 rst=1 SHALL immediately force the following, at any state including mid-FEED or mid-DRAIN:
- state=IDLE, k=0, idx=0.
- W_en=0, res_valid=0, busy=0, done=0.
- All operand outputs and res_data/res_idx = 0.
REQ-023 A, B and C storage SHALL be cleared to 0 on reset.
REQ-024 After rst deasserts, no operation SHALL start without a fresh start pulse.

Structure
REQ-025 A shared package SHALL hold N, DW, RW, the state enumeration and the constant LAST_IDX=8.
REQ-026 The design SHALL contain one sub-module, matmul_regfile: the A/B 9x8 storage with a write port and the row/column read mux.
REQ-027 The C buffer and the FSM SHALL remain in matmul_ctrl.
REQ-028 The mac unit SHALL be instantiated beside matmul_ctrl at top level, not inside it.

Verification
REQ-029 Identity test: A=I, B=1..9, start, res_ready=1 -> res_data 1..9 in idx order 0..8, done pulses once, busy=0 afterwards.
REQ-030 Overflow test: A all 127, B all -128 -> every res_data=16768 (0x4180, -48768 wrapped to 16 bits).
REQ-031 Backpressure test: res_ready low for 5 cycles at idx=4 -> res_data/res_idx held constant, no index skipped, 9 transfers total.
REQ-032 Reset mid-operation test: rst pulsed at the 7th FEED -> all outputs 0 asynchronously; new loads and start then give the correct C.
REQ-033 Protocol test: start re-pulsed and ld_en asserted during busy -> no restart, A/B unchanged, W_en high exactly 9 cycles per operation.

Source files
------------

// File: rtl/matmul_ctrl_pkg.sv
// Shared constants, FSM state encoding and element-index helpers for the
// 3x3 matrix-multiply controller.
package matmul_ctrl_pkg;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int RW = 16;

  localparam logic [3:0] LAST_IDX = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    CAPT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Row-major element index k maps to C row i = k / 3 and column j = k % 3.
  function automatic logic [1:0] k_row(input logic [3:0] k);
    return 2'(k / 4'd3);
  endfunction

  function automatic logic [1:0] k_col(input logic [3:0] k);
    return 2'(k % 4'd3);
  endfunction

endpackage

// File: rtl/matmul_ctrl_if.sv
// Host-side bus of the matmul controller: operand loading, start/status and
// the result stream.
interface matmul_ctrl_if #(
    parameter int DW = matmul_ctrl_pkg::DW,
    parameter int RW = matmul_ctrl_pkg::RW
);

    logic                 ld_en;
    logic                 ld_sel;
    logic [3:0]           ld_addr;
    logic signed [DW-1:0] ld_data;
    logic                 start;
    logic                 busy;
    logic                 done;

    // Result stream: a transfer happens on a rising clk edge where res_valid
    // and res_ready are both 1; while res_valid=1 and res_ready=0 the source
    // holds res_data/res_idx, and res_valid never drops without a transfer.
    logic                 res_valid;
    logic                 res_ready;
    logic signed [RW-1:0] res_data;
    logic [3:0]           res_idx;

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, res_ready,
        input  busy, done, res_valid, res_data, res_idx
    );

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, res_ready,
        output busy, done, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/matmul_regfile.sv
// A/B operand storage (row-major, 9 entries each) with one write port and a
// combinational A-row / B-column read mux.
module matmul_regfile #(
    parameter int N  = matmul_ctrl_pkg::N,
    parameter int DW = matmul_ctrl_pkg::DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic                   sel,
    input  logic [3:0]             addr,
    input  logic [DW-1:0]          wdata,
    input  logic [1:0]             row,
    input  logic [1:0]             col,
    output logic [N-1:0][DW-1:0]   a_row,
    output logic [N-1:0][DW-1:0]   b_col
);
    import matmul_ctrl_pkg::*;

    logic [DW-1:0] a_mem [N*N];
    logic [DW-1:0] b_mem [N*N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N*N; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
            end
        end else if (we && addr <= LAST_IDX) begin
            if (sel) b_mem[addr] <= wdata;
            else     a_mem[addr] <= wdata;
        end
    end

    always_comb begin
        a_row = '0;
        b_col = '0;
        for (int n = 0; n < N; n++) begin
            a_row[n] = a_mem[int'(row)*N + n];
            b_col[n] = b_mem[n*N + int'(col)];
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// Sequences a 3x3 matrix multiply through an external MAC: one FEED/CAPT pair
// per C element, then streams C out over a valid/ready port.
module matmul_ctrl #(
    parameter int N  = matmul_ctrl_pkg::N,
    parameter int DW = matmul_ctrl_pkg::DW,
    parameter int RW = matmul_ctrl_pkg::RW
) (
    input  logic                 clk,
    input  logic                 rst,
    matmul_ctrl_if.slave         host,
    output logic signed [DW-1:0] a_i_0,
    output logic signed [DW-1:0] a_i_1,
    output logic signed [DW-1:0] a_i_2,
    output logic signed [DW-1:0] b_j_0,
    output logic signed [DW-1:0] b_j_1,
    output logic signed [DW-1:0] b_j_2,
    output logic                 W_en,
    input  logic signed [RW-1:0] SOP
);
    import matmul_ctrl_pkg::*;

    state_t               state_q, state_d;
    logic [3:0]           k_q, idx_q;
    logic                 done_q;
    logic                 ops_en;
    logic                 load_we;
    logic [1:0]           row, col;
    logic [N-1:0][DW-1:0] a_row, b_col;
    logic signed [RW-1:0] c_mem [N*N];

    assign load_we = host.ld_en && (state_q == IDLE);
    assign row     = k_row(k_q);
    assign col     = k_col(k_q);

    matmul_regfile #(.N(N), .DW(DW)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (load_we),
        .sel   (host.ld_sel),
        .addr  (host.ld_addr),
        .wdata (host.ld_data),
        .row   (row),
        .col   (col),
        .a_row (a_row),
        .b_col (b_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        W_en           = 1'b0;
        ops_en         = 1'b0;
        host.res_valid = 1'b0;
        host.res_data  = '0;
        host.res_idx   = '0;
        case (state_q)
            IDLE:  if (host.start) state_d = FEED;
            FEED: begin
                W_en    = 1'b1;
                ops_en  = 1'b1;
                state_d = CAPT;
            end
            CAPT: begin
                ops_en  = 1'b1;
                state_d = (k_q == LAST_IDX) ? DRAIN : FEED;
            end
            DRAIN: begin
                host.res_valid = 1'b1;
                host.res_data  = c_mem[idx_q];
                host.res_idx   = idx_q;
                if (host.res_ready && idx_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are gated by state so reset zeroes them without waiting a clock.
    assign a_i_0 = ops_en ? a_row[0] : '0;
    assign a_i_1 = ops_en ? a_row[1] : '0;
    assign a_i_2 = ops_en ? a_row[2] : '0;
    assign b_j_0 = ops_en ? b_col[0] : '0;
    assign b_j_1 = ops_en ? b_col[1] : '0;
    assign b_j_2 = ops_en ? b_col[2] : '0;

    assign host.busy = (state_q != IDLE);
    assign host.done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            for (int n = 0; n < N*N; n++) c_mem[n] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (host.start) k_q <= '0;
                CAPT: begin
                    c_mem[k_q] <= SOP;
                    if (k_q == LAST_IDX) idx_q <= '0;
                    else                 k_q   <= k_q + 4'd1;
                end
                DRAIN: begin
                    if (host.res_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Randomized bench for matmul_ctrl: a matrix-level reference model, a MAC
// model driving SOP, and one per-cycle compare process.
module tb_matmul_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_ctrl_if bus ();

  logic signed [7:0]  a_i_0, a_i_1, a_i_2, b_j_0, b_j_1, b_j_2;
  logic               W_en;
  logic signed [15:0] sop = '0;

  matmul_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .host  (bus),
    .a_i_0 (a_i_0),
    .a_i_1 (a_i_1),
    .a_i_2 (a_i_2),
    .b_j_0 (b_j_0),
    .b_j_1 (b_j_1),
    .b_j_2 (b_j_2),
    .W_en  (W_en),
    .SOP   (sop)
  );

  // MAC model: registers the 3-term dot product, wrapped to 16 bits.
  always @(posedge clk) begin
    if (W_en)
      sop <= 16'(int'(a_i_0) * int'(b_j_0) + int'(a_i_1) * int'(b_j_1) + int'(a_i_2) * int'(b_j_2));
  end

  int checks = 0;
  int failures = 0;
  int ma [9];
  int mb [9];
  logic [19:0] exp_q [$];
  int rx [9];
  int op_feeds = 0;
  int op_xfers = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference C = A x B from the model matrices, in row-major transfer order.
  function automatic void build_exp();
    for (int k = 0; k < 9; k++) begin
      int s;
      s = 0;
      for (int n = 0; n < 3; n++) s += ma[(k/3)*3 + n] * mb[n*3 + (k%3)];
      exp_q.push_back({4'(k), 16'(s)});
    end
  endfunction

  function automatic void model_write(input bit sel, input int addr, input int data);
    logic signed [7:0] t;
    t = 8'(data);
    if (addr <= 8) begin
      if (sel) mb[addr] = int'(t);
      else     ma[addr] = int'(t);
    end
  endfunction

  // ---------------- compare process ----------------
  bit          prev_wen = 1'b0;
  bit          prev_stall = 1'b0;
  int          prev_data, prev_idx, kk;
  int          ops [6];
  int          prev_ops [6];
  logic [19:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_wen   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      ops = '{int'(a_i_0), int'(a_i_1), int'(a_i_2), int'(b_j_0), int'(b_j_1), int'(b_j_2)};
      if (W_en) begin
        op_feeds++;
        kk = op_feeds - 1;
        if (kk <= 8) begin
          for (int n = 0; n < 3; n++) begin
            check("a_operand", ops[n], ma[(kk/3)*3 + n]);
            check("b_operand", ops[3+n], mb[n*3 + (kk%3)]);
          end
        end else begin
          check("wen_pulses", op_feeds, 9);
        end
      end else if (prev_wen) begin
        for (int n = 0; n < 6; n++) check("operand_hold", ops[n], prev_ops[n]);
      end else begin
        for (int n = 0; n < 6; n++) check("operand_idle_zero", ops[n], 0);
      end

      if (!bus.res_valid) begin
        check("res_data_idle", int'(bus.res_data), 0);
        check("res_idx_idle", int'(bus.res_idx), 0);
        if (prev_stall) check("valid_dropped_in_stall", 0, 1);
      end else begin
        if (prev_stall) begin
          check("stall_data_stable", int'(bus.res_data), prev_data);
          check("stall_idx_stable", int'(bus.res_idx), prev_idx);
        end
        if (bus.res_ready) begin
          op_xfers++;
          if (exp_q.size() == 0) begin
            check("unexpected_transfer", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("res_idx", int'(bus.res_idx), int'(e[19:16]));
            check("res_data", int'(bus.res_data), int'($signed(e[15:0])));
            if (bus.res_idx <= 4'd8) rx[bus.res_idx] = int'(bus.res_data);
          end
        end
      end
      prev_stall = bus.res_valid && !bus.res_ready;
      prev_data  = int'(bus.res_data);
      prev_idx   = int'(bus.res_idx);

      if (bus.done) begin
        done_cnt++;
        check("busy_low_at_done", int'(bus.busy), 0);
      end
      prev_wen = W_en;
      prev_ops = ops;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input bit sel, input int addr, input int data);
    bus.ld_en   = 1'b1;
    bus.ld_sel  = sel;
    bus.ld_addr = 4'(addr);
    bus.ld_data = 8'(data);
    @(posedge clk); #1;
    bus.ld_en = 1'b0;
    model_write(sel, addr, data);
  endtask

  task automatic load_random();
    for (int i = 0; i < 9; i++) begin
      load(1'b0, i, $urandom_range(0, 255));
      load(1'b1, i, $urandom_range(0, 255));
    end
    for (int i = 0; i < 3; i++) load(1'($urandom_range(0, 1)), $urandom_range(9, 15), $urandom_range(0, 255));
  endtask

  task automatic poke_busy_inputs();
    bus.start   = 1'b1;
    bus.ld_en   = 1'b1;
    bus.ld_sel  = 1'($urandom_range(0, 1));
    bus.ld_addr = 4'($urandom_range(0, 8));
    bus.ld_data = 8'($urandom_range(0, 255));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low 5 cycles at idx 4.
  task automatic run_op(input int mode, input bit proto, input bit cl_en,
                        input bit cl_sel, input int cl_addr, input int cl_data);
    int cnt, guard, hold, d0;
    bit seen4;
    for (int i = 0; i < 9; i++) rx[i] = -1;
    if (cl_en) model_write(cl_sel, cl_addr, cl_data);
    build_exp();
    op_feeds = 0;
    op_xfers = 0;
    d0 = done_cnt;
    bus.start   = 1'b1;
    bus.ld_en   = cl_en;
    bus.ld_sel  = cl_sel;
    bus.ld_addr = 4'(cl_addr);
    bus.ld_data = 8'(cl_data);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    check("busy_rise", int'(bus.busy), 1);
    cnt = 0;
    while (!bus.res_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (proto && cnt == 3) poke_busy_inputs();
      else begin
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
      end
    end
    check("compute_cycles", cnt, 18);
    guard = 0;
    hold  = 0;
    seen4 = 1'b0;
    while (!bus.done && guard < 200) begin
      case (mode)
        0: bus.res_ready = 1'b1;
        1: bus.res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.res_idx == 4'd4 && !seen4) begin
            seen4 = 1'b1;
            hold  = 5;
          end
          if (hold > 0) begin
            bus.res_ready = 1'b0;
            hold--;
          end else begin
            bus.res_ready = 1'b1;
          end
        end
      endcase
      if (proto && guard == 0) poke_busy_inputs();
      else begin
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    check("done_seen", int'(bus.done), 1);
    if (mode == 2) check("stall_seen_at_idx4", int'(seen4), 1);
    @(posedge clk); #1;
    check("done_one_cycle", int'(bus.done), 0);
    check("idle_after_done", int'(bus.busy), 0);
    check("done_pulses", done_cnt - d0, 1);
    check("transfers", op_xfers, 9);
    check("wen_cycles", op_feeds, 9);
    check("exp_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_op();
    int wen, guard;
    load_random();
    build_exp();
    op_feeds = 0;
    op_xfers = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wen = 0;
    guard = 0;
    while (guard < 40) begin
      if (W_en) wen++;
      if (wen == 7) break;
      @(posedge clk); #1;
      guard++;
    end
    check("reached_feed7", wen, 7);
    #2 rst = 1'b1;
    #1;
    check("rst_wen", int'(W_en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_valid", int'(bus.res_valid), 0);
    check("rst_data", int'(bus.res_data), 0);
    check("rst_idx", int'(bus.res_idx), 0);
    check("rst_a_ops", int'(a_i_0) | int'(a_i_1) | int'(a_i_2), 0);
    check("rst_b_ops", int'(b_j_0) | int'(b_j_1) | int'(b_j_2), 0);
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_restart_busy", int'(bus.busy), 0);
    check("no_restart_wen", int'(W_en), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.ld_en = 1'b0;
    bus.ld_sel = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.start = 1'b0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_valid", int'(bus.res_valid), 0);
    check("reset_wen", int'(W_en), 0);
    check("reset_data", int'(bus.res_data), 0);
    check("reset_idx", int'(bus.res_idx), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity: C must equal B = 1..9.
    for (int i = 0; i < 9; i++) begin
      load(1'b0, i, (i / 3 == i % 3) ? 1 : 0);
      load(1'b1, i, i + 1);
    end
    run_op(0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) check("identity_c", rx[i], i + 1);

    // Overflow: 3*127*-128 = -48768 wraps to 16768; last B load rides with start.
    for (int i = 0; i < 9; i++) load(1'b0, i, 127);
    for (int i = 0; i < 8; i++) load(1'b1, i, -128);
    run_op(0, 1'b0, 1'b1, 1'b1, 8, -128);
    for (int i = 0; i < 9; i++) check("overflow_c", rx[i], 16768);

    repeat (3) begin
      load_random();
      run_op(1, 1'b0, 1'b0, 1'b0, 0, 0);
    end

    load_random();
    run_op(2, 1'b0, 1'b0, 1'b0, 0, 0);

    load_random();
    run_op(0, 1'b1, 1'b1, 1'b0, $urandom_range(0, 8), $urandom_range(0, 255));
    run_op(1, 1'b0, 1'b0, 1'b0, 0, 0);

    reset_mid_op();
    run_op(0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) check("cleared_c", rx[i], 0);
    load_random();
    run_op(1, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
